// File: rtl/mc_pkg.sv
// Shared MC ISA definitions: word width, NOP encoding and opcode ranges.
// Used by the MC sequencer and by insn_pipe_fifo.
package mc_pkg;

  localparam int ISA_W = 32;
  localparam logic [ISA_W-1:0] ISA_NOP = 32'h0000_0000;

  localparam logic [7:0] OPC_NOP       = 8'h00;
  localparam logic [7:0] OPC_ISA_FIRST = 8'h01;
  localparam logic [7:0] OPC_ISA_LAST  = 8'h07;
  localparam logic [7:0] OPC_ALU_FIRST = 8'h10;
  localparam logic [7:0] OPC_ALU_LAST  = 8'h14;
  localparam logic [7:0] OPC_EXT_FIRST = 8'h20;
  localparam logic [7:0] OPC_EXT_LAST  = 8'h23;

  function automatic logic is_valid_op(input logic [7:0] op);
    return (op == OPC_NOP) ||
           ((op >= OPC_ISA_FIRST) && (op <= OPC_ISA_LAST)) ||
           ((op >= OPC_ALU_FIRST) && (op <= OPC_ALU_LAST)) ||
           ((op >= OPC_EXT_FIRST) && (op <= OPC_EXT_LAST));
  endfunction

endpackage

// File: rtl/insn_fifo_ram.sv
// Simple dual-port word array for the instruction FIFO.
// Synchronous write, asynchronous read (feeds the fall-through head).
module insn_fifo_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/insn_pipe_fifo.sv
// Packs 16-bit host half-words into 32-bit ISA words and buffers them in a FWFT FIFO for MC.
// Define INSN_PIPE_CHK_EN to drop words with an unknown opcode byte and raise bad_op.
module insn_pipe_fifo
  import mc_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  pipe_valid,
  input  logic [15:0]           pipe_data,
  output logic                  pipe_ready,
  input  logic                  rd,
  output logic [ISA_W-1:0]      dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  half_pend,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  bad_op
);

  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [15:0]           r_lo_hold;
  logic                  r_half_pend;
  logic                  r_overflow, r_underflow, r_bad_op;

  logic              w_full, w_empty, w_accept, w_word_done, w_op_ok, w_wr, w_rd;
  logic [ISA_W-1:0]  w_word, w_rdata;

  assign w_full      = (r_level == LVL_FULL);
  assign w_empty     = (r_level == '0);
  assign w_accept    = pipe_valid && !w_full;
  assign w_word_done = w_accept && r_half_pend;
  assign w_word      = {pipe_data, r_lo_hold};

`ifdef INSN_PIPE_CHK_EN
  assign w_op_ok = is_valid_op(w_word[7:0]);
`else
  assign w_op_ok = 1'b1;
`endif

  assign w_wr = w_word_done && w_op_ok;
  assign w_rd = rd && !w_empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_lo_hold   <= '0;
      r_half_pend <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_bad_op    <= 1'b0;
    end else begin
      if (w_accept && !r_half_pend) r_lo_hold <= pipe_data;
      if (w_accept) r_half_pend <= !r_half_pend;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (pipe_valid && w_full) r_overflow <= 1'b1;
      if (rd && w_empty) r_underflow <= 1'b1;
      // Only reachable when opcode checking is compiled in.
      if (w_word_done && !w_op_ok) r_bad_op <= 1'b1;
    end
  end

  insn_fifo_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (ISA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_word),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign pipe_ready = !w_full;
  assign empty      = w_empty;
  assign dout       = w_empty ? ISA_NOP : w_rdata;
  assign level      = r_level;
  assign half_pend  = r_half_pend;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign bad_op     = r_bad_op;

endmodule

// File: tb/tb_insn_pipe_fifo.sv
// Scoreboard bench for insn_pipe_fifo: packing, fill/overflow, wrap, underflow, flush, opcode check.
module tb_insn_pipe_fifo;

  localparam int DL2   = 9;
  localparam int DEPTH = 1 << DL2;

  logic            clk = 1'b0;
  logic            rst, flush, pipe_valid, rd;
  logic [15:0]     pipe_data;
  logic            pipe_ready, empty, half_pend, overflow, underflow, bad_op;
  logic [31:0]     dout;
  logic [DL2:0]    level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_w;

  always #5 clk = ~clk;

  insn_pipe_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .rd(rd), .dout(dout), .empty(empty), .level(level),
    .half_pend(half_pend), .overflow(overflow), .underflow(underflow), .bad_op(bad_op)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    pipe_valid = 1'b1;
    pipe_data  = w[15:0];
    step();
    pipe_data  = w[31:16];
    step();
    pipe_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; pipe_valid = 1'b0; pipe_data = 16'h0; rd = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
    n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", pipe_ready); end
    n_checks++; if ({half_pend, overflow, underflow, bad_op} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {half_pend, overflow, underflow, bad_op});
    end
  endtask

  task automatic test_pack();
    pipe_valid = 1'b1; pipe_data = 16'h0005;
    step();
    n_checks++; if (half_pend !== 1'b1) begin n_fail++; $display("FAIL pack_half_pend got %b want 1", half_pend); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pack_empty_mid got %b want 1", empty); end
    pipe_data = 16'h1234;
    step();
    pipe_valid = 1'b0;
    sb.push_back(32'h1234_0005);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL pack_empty got %b want 0", empty); end
    n_checks++; if (half_pend !== 1'b0) begin n_fail++; $display("FAIL pack_half_clr got %b want 0", half_pend); end
    n_checks++; if (level !== 1) begin n_fail++; $display("FAIL pack_level got %0d want 1", level); end
    exp_w = sb.pop_front();
    n_checks++; if (dout !== exp_w) begin n_fail++; $display("FAIL pack_dout got %h want %h", dout, exp_w); end
    rd = 1'b1; step(); rd = 1'b0;
    n_checks++; if (empty !== 1'b1 || dout !== 32'h0) begin
      n_fail++; $display("FAIL pack_drain got empty=%b dout=%h want 1/0", empty, dout);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = {i[15:0], 8'hA5, 8'h01 + 8'(i % 7)};
      send_word(w);
      sb.push_back(w);
    end
    n_checks++; if (level !== DEPTH) begin n_fail++; $display("FAIL fill_level got %0d want %0d", level, DEPTH); end
    n_checks++; if (pipe_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %b want 0", pipe_ready); end
    pipe_valid = 1'b1; pipe_data = 16'hDEAD;
    step();
    pipe_valid = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_checks++; if (level !== DEPTH) begin n_fail++; $display("FAIL ovf_level got %0d want %0d", level, DEPTH); end
    n_checks++; if (half_pend !== 1'b0) begin n_fail++; $display("FAIL ovf_phase got %b want 0", half_pend); end
    exp_w = sb.pop_front();
    n_checks++; if (dout !== exp_w) begin n_fail++; $display("FAIL full_head got %h want %h", dout, exp_w); end
    rd = 1'b1; step(); rd = 1'b0;
    n_checks++; if (level !== DEPTH - 1) begin n_fail++; $display("FAIL pop_level got %0d want %0d", level, DEPTH - 1); end
    n_checks++; if (pipe_ready !== 1'b1) begin n_fail++; $display("FAIL pop_ready got %b want 1", pipe_ready); end
    while (sb.size() > 0) begin
      exp_w = sb.pop_front();
      n_checks++; if (dout !== exp_w) begin n_fail++; $display("FAIL drain_order got %h want %h", dout, exp_w); end
      rd = 1'b1; step(); rd = 1'b0;
    end
    n_checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL drain_end got empty=%b ovf=%b want 1/1", empty, overflow);
    end
  endtask

  task automatic test_simul_wrap();
    send_word(32'hAAAA_0011);
    sb.push_back(32'hAAAA_0011);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      w = {16'(i * 3 + 7), 8'h5A, 8'h20 + 8'(i % 4)};
      pipe_valid = 1'b1; pipe_data = w[15:0];
      step();
      pipe_data = w[31:16];
      exp_w = sb.pop_front();
      n_checks++; if (dout !== exp_w) begin n_fail++; $display("FAIL wrap_order got %h want %h", dout, exp_w); end
      rd = 1'b1;
      sb.push_back(w);
      step();
      rd = 1'b0; pipe_valid = 1'b0;
      n_checks++; if (level !== 1) begin n_fail++; $display("FAIL simul_level got %0d want 1", level); end
    end
    exp_w = sb.pop_front();
    n_checks++; if (dout !== exp_w) begin n_fail++; $display("FAIL wrap_last got %h want %h", dout, exp_w); end
    rd = 1'b1; step(); rd = 1'b0;
  endtask

  task automatic test_underflow_flush();
    flush = 1'b1; step(); flush = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf got %b want 0", overflow); end
    rd = 1'b1; step(); rd = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_flag got %b want 1", underflow); end
    n_checks++; if (level !== 0 || dout !== 32'h0) begin
      n_fail++; $display("FAIL udf_state got level=%0d dout=%h want 0/0", level, dout);
    end
    pipe_valid = 1'b1; pipe_data = 16'hBEEF; step(); pipe_valid = 1'b0;
    n_checks++; if (half_pend !== 1'b1) begin n_fail++; $display("FAIL flush_pre got %b want 1", half_pend); end
    flush = 1'b1; step(); flush = 1'b0;
    n_checks++; if (half_pend !== 1'b0 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_clr got hp=%b udf=%b want 0/0", half_pend, underflow);
    end
    send_word(32'h5678_0003);
    sb.push_back(32'h5678_0003);
    exp_w = sb.pop_front();
    n_checks++; if (dout !== exp_w || level !== 1) begin
      n_fail++; $display("FAIL flush_word got %h lvl=%0d want %h lvl=1", dout, level, exp_w);
    end
    rd = 1'b1; step(); rd = 1'b0;
  endtask

  task automatic test_opcode_check();
    send_word(32'h0000_0099);
`ifdef INSN_PIPE_CHK_EN
    n_checks++; if (level !== 0 || bad_op !== 1'b1) begin
      n_fail++; $display("FAIL chk_bad got lvl=%0d bad=%b want 0/1", level, bad_op);
    end
`else
    sb.push_back(32'h0000_0099);
    exp_w = sb.pop_front();
    n_checks++; if (dout !== exp_w || bad_op !== 1'b0) begin
      n_fail++; $display("FAIL nochk_word got %h bad=%b want %h/0", dout, bad_op, exp_w);
    end
    rd = 1'b1; step(); rd = 1'b0;
`endif
    send_word(32'h0000_0023);
    sb.push_back(32'h0000_0023);
    exp_w = sb.pop_front();
    n_checks++; if (dout !== exp_w || level !== 1) begin
      n_fail++; $display("FAIL chk_good got %h lvl=%0d want %h lvl=1", dout, level, exp_w);
    end
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++; if (empty !== 1'b1 || bad_op !== 1'b0) begin
      n_fail++; $display("FAIL rst_clr got empty=%b bad=%b want 1/0", empty, bad_op);
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_fill_overflow();
    test_simul_wrap();
    test_underflow_flush();
    test_opcode_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
